// File: rtl/multicycle_controller_pkg.sv
// rtl/multicycle_controller_pkg.sv - shared encodings for the multicycle RV32 control FSM
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BEQ,
        S_JAL,
        S_TRAP
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Operation class handed to the ALU decoder.
    localparam logic [1:0] ALU_OP_ADD = 2'b00;
    localparam logic [1:0] ALU_OP_SUB = 2'b01;
    localparam logic [1:0] ALU_OP_R   = 2'b10;
    localparam logic [1:0] ALU_OP_I   = 2'b11;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;

    localparam logic [1:0] SRC_B_RS2    = 2'b00;
    localparam logic [1:0] SRC_B_IMM    = 2'b01;
    localparam logic [1:0] SRC_B_FOUR   = 2'b10;

    localparam logic [1:0] RES_ALUOUT   = 2'b00;
    localparam logic [1:0] RES_MEMDATA  = 2'b01;
    localparam logic [1:0] RES_ALU      = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// rtl/multicycle_controller_alu_decoder.sv - combinational ALU control decode from op class and funct fields
module multicycle_controller_alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALU_OP_SUB: alu_control = ALU_SUB;
            ALU_OP_R, ALU_OP_I: begin
                case (funct3)
                    // funct7b5 is part of the immediate for I-type, so it never selects sub there
                    3'b000:  alu_control = (alu_op == ALU_OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - main control FSM sequencing the shared datapath of the multicycle RV32 core
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       result_src,
    output logic [2:0]       alu_control,
    output logic [1:0]       imm_src,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    state_e           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [1:0]       imm_src_q, imm_src_d;

    logic [1:0] alu_op;
    logic       retire;
    logic       mem_req_raw, mem_write_raw, ir_write_raw, pc_write_raw, reg_write_raw;

    multicycle_controller_alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .alu_control (alu_control)
    );

    always_comb begin
        state_d       = state_q;
        imm_src_d     = imm_src_q;
        alu_op        = ALU_OP_ADD;
        retire        = 1'b0;
        mem_req_raw   = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        pc_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        adr_src       = 1'b0;
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_RS2;
        result_src    = RES_ALUOUT;

        case (state_q)
            S_FETCH: begin
                mem_req_raw  = 1'b1;
                alu_src_a    = SRC_A_PC;
                alu_src_b    = SRC_B_FOUR;
                result_src   = RES_ALU;
                ir_write_raw = mem_ready;
                pc_write_raw = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is computed here so BEQ can reuse it from ALUOut.
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
                imm_src_d = IMM_B;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC_R;
                    OP_I:         state_d = S_EXEC_I;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                if (opcode == OP_SW) begin
                    imm_src_d = IMM_S;
                    state_d   = S_MEMWRITE;
                end else begin
                    imm_src_d = IMM_I;
                    state_d   = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                mem_req_raw = 1'b1;
                adr_src     = 1'b1;
                result_src  = RES_ALUOUT;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src    = RES_MEMDATA;
                reg_write_raw = 1'b1;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_raw   = 1'b1;
                mem_write_raw = 1'b1;
                adr_src       = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_RS2;
                alu_op    = ALU_OP_R;
                state_d   = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                imm_src_d = IMM_I;
                alu_op    = ALU_OP_I;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                result_src    = RES_ALUOUT;
                reg_write_raw = 1'b1;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a    = SRC_A_RS1;
                alu_src_b    = SRC_B_RS2;
                alu_op       = ALU_OP_SUB;
                result_src   = RES_ALUOUT;
                pc_write_raw = zero;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_JAL: begin
                alu_src_a    = SRC_A_OLD_PC;
                alu_src_b    = SRC_B_FOUR;
                result_src   = RES_ALUOUT;
                pc_write_raw = 1'b1;
                imm_src_d    = IMM_J;
                state_d      = S_ALUWB;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        illegal_d = illegal_q | (state_d == S_TRAP);
        instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
    end

    // Reset aborts the current instruction, so no side effect may leak out in that cycle.
    assign mem_req   = mem_req_raw   & ~reset;
    assign mem_write = mem_write_raw & ~reset;
    assign ir_write  = ir_write_raw  & ~reset;
    assign pc_write  = pc_write_raw  & ~reset;
    assign reg_write = reg_write_raw & ~reset;
    assign imm_src   = imm_src_d;
    assign illegal   = illegal_q;
    assign instret   = instret_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            instret_q <= '0;
            imm_src_q <= IMM_I;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
            imm_src_q <= imm_src_d;
        end
    end

endmodule
